dmem_arbiter: RTL and testbench

Shares the single memory-side port below the data cache between `NUM_REQ` requesters: D-cache miss fill/write-through, I-fetch fill, and future prefetch. Grants round-robin, carries one outstanding transaction at a time, and returns load data or store completion to the granted requester. A watchdog flags memory responses that never arrive. It sits between the cache layer and the memory model/bus.

---
 rtl/dmem_arbiter_pkg.sv | 26 ++
 rtl/dmem_arbiter_rr.sv | 37 +++
 rtl/dmem_arbiter.sv | 158 +++++++++++++++
 tb/tb_dmem_arbiter.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arbiter_pkg.sv
// ============================================================================
// dmem_arbiter_pkg : shared types for the data-memory port arbiter
// Rev 1.0
// ============================================================================
`default_nettype none

package dmem_arbiter_pkg;

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {
    MEM_NONE  = 2'd0,
    MEM_LOAD  = 2'd1,
    MEM_STORE = 2'd2
  } mem_cmd_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } arb_state_t;

endpackage

`default_nettype wire

// File: rtl/dmem_arbiter_rr.sv
// ============================================================================
// rr_arbiter : combinational N-way round-robin picker (pointer = top priority)
// Rev 1.0
// ============================================================================
`default_nettype none

module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int IDXW    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDXW-1:0]    ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IDXW-1:0]    idx_o,
  output logic               any_o
);

  logic [IDXW-1:0] cand;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    cand  = '0;
    for (int off = 0; off < NUM_REQ; off++) begin
      cand = IDXW'((int'(ptr_i) + off) % NUM_REQ);
      if (!any_o && req_i[cand]) begin
        any_o       = 1'b1;
        gnt_o[cand] = 1'b1;
        idx_o       = cand;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/dmem_arbiter.sv
// ============================================================================
// dmem_arbiter : round-robin sharing of one memory port, one transaction in
//                flight, with a response watchdog. Rev 1.0
// ============================================================================
`default_nettype none

module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int TIMEOUT = 64
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  input  logic [NUM_REQ-1:0]            req_write_i,
  input  logic [NUM_REQ-1:0][XLEN-1:0]  req_addr_i,
  input  logic [NUM_REQ-1:0][XLEN-1:0]  req_wdata_i,
  output logic [NUM_REQ-1:0]            req_ready_o,
  output logic [NUM_REQ-1:0]            resp_valid_o,
  output logic [XLEN-1:0]               resp_data_o,
  output logic                          resp_err_o,
  output logic [1:0]                    mem_cmd_o,
  output logic [XLEN-1:0]               mem_addr_o,
  output logic [XLEN-1:0]               mem_wdata_o,
  input  logic                          mem_ack_i,
  input  logic                          mem_rvalid_i,
  input  logic [XLEN-1:0]               mem_rdata_i
);

  localparam int IDXW = $clog2(NUM_REQ);
  localparam int WD_W = $clog2(TIMEOUT);
  localparam logic [IDXW-1:0] IDX_LAST = IDXW'(NUM_REQ - 1);
  localparam logic [WD_W-1:0] WD_LAST  = WD_W'(TIMEOUT - 1);

  arb_state_t           state_q,      state_d;
  logic [IDXW-1:0]      rr_ptr_q,     rr_ptr_d;
  logic [IDXW-1:0]      idx_q,        idx_d;
  logic [WD_W-1:0]      wd_q,         wd_d;
  mem_cmd_t             mem_cmd_q,    mem_cmd_d;
  logic [XLEN-1:0]      mem_addr_q,   mem_addr_d;
  logic [XLEN-1:0]      mem_wdata_q,  mem_wdata_d;
  logic [NUM_REQ-1:0]   req_ready_q,  req_ready_d;
  logic [NUM_REQ-1:0]   resp_valid_q, resp_valid_d;
  logic [XLEN-1:0]      resp_data_q,  resp_data_d;
  logic                 resp_err_q,   resp_err_d;

  logic [NUM_REQ-1:0]   arb_gnt;
  logic [IDXW-1:0]      arb_idx;
  logic                 arb_any;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDXW    (IDXW)
  ) u_rr (
    .req_i (req_valid_i),
    .ptr_i (rr_ptr_q),
    .gnt_o (arb_gnt),
    .idx_o (arb_idx),
    .any_o (arb_any)
  );

  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    idx_d        = idx_q;
    wd_d         = wd_q;
    mem_cmd_d    = mem_cmd_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    req_ready_d  = '0;
    resp_valid_d = '0;
    resp_data_d  = '0;
    resp_err_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (arb_any) begin
          idx_d       = arb_idx;
          req_ready_d = arb_gnt;
          mem_cmd_d   = req_write_i[arb_idx] ? MEM_STORE : MEM_LOAD;
          mem_addr_d  = req_addr_i[arb_idx];
          mem_wdata_d = req_wdata_i[arb_idx];
          state_d     = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (mem_ack_i) begin
          mem_cmd_d = MEM_NONE;
          if (mem_cmd_q == MEM_STORE) begin
            resp_valid_d[idx_q] = 1'b1;
            state_d             = ST_RESP;
          end else begin
            wd_d    = '0;
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (wd_q != WD_LAST) wd_d = wd_q + WD_W'(1);
        // A late rvalid on the expiry cycle still wins over the timeout.
        if (mem_rvalid_i) begin
          resp_valid_d[idx_q] = 1'b1;
          resp_data_d         = mem_rdata_i;
          state_d             = ST_RESP;
        end else if (wd_q == WD_LAST) begin
          resp_valid_d[idx_q] = 1'b1;
          resp_err_d          = 1'b1;
          state_d             = ST_RESP;
        end
      end
      ST_RESP: begin
        rr_ptr_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDXW'(1);
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      rr_ptr_q     <= '0;
      idx_q        <= '0;
      wd_q         <= '0;
      mem_cmd_q    <= MEM_NONE;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      req_ready_q  <= '0;
      resp_valid_q <= '0;
      resp_data_q  <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      idx_q        <= idx_d;
      wd_q         <= wd_d;
      mem_cmd_q    <= mem_cmd_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      resp_err_q   <= resp_err_d;
    end
  end

  assign req_ready_o  = req_ready_q;
  assign resp_valid_o = resp_valid_q;
  assign resp_data_o  = resp_data_q;
  assign resp_err_o   = resp_err_q;
  assign mem_cmd_o    = mem_cmd_q;
  assign mem_addr_o   = mem_addr_q;
  assign mem_wdata_o  = mem_wdata_q;

endmodule

`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
// ============================================================================
// tb_dmem_arbiter : directed scenarios plus randomized transactions checked
//                   against a transaction-level model. Rev 1.0
// ============================================================================
`default_nettype none

module tb_dmem_arbiter;
  import dmem_arbiter_pkg::*;

  localparam int N  = 3;
  localparam int TO = 8;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic [N-1:0]           req_valid = '0;
  logic [N-1:0]           req_write = '0;
  logic [N-1:0][31:0]     req_addr  = '0;
  logic [N-1:0][31:0]     req_wdata = '0;
  logic [N-1:0]           req_ready;
  logic [N-1:0]           resp_valid;
  logic [31:0]            resp_data;
  logic                   resp_err;
  logic [1:0]             mem_cmd;
  logic [31:0]            mem_addr;
  logic [31:0]            mem_wdata;
  logic                   mem_ack = 1'b0;
  logic                   mem_rvalid = 1'b0;
  logic [31:0]            mem_rdata = '0;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.NUM_REQ(N), .TIMEOUT(TO)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid_i  (req_valid),
    .req_write_i  (req_write),
    .req_addr_i   (req_addr),
    .req_wdata_i  (req_wdata),
    .req_ready_o  (req_ready),
    .resp_valid_o (resp_valid),
    .resp_data_o  (resp_data),
    .resp_err_o   (resp_err),
    .mem_cmd_o    (mem_cmd),
    .mem_addr_o   (mem_addr),
    .mem_wdata_o  (mem_wdata),
    .mem_ack_i    (mem_ack),
    .mem_rvalid_i (mem_rvalid),
    .mem_rdata_i  (mem_rdata)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [N-1:0] oh(input int i);
    return N'(1) << i;
  endfunction

  initial begin
    #300000;
    $display("FAIL deadline: simulation did not finish");
    $fatal(1, "deadline expired");
  end

  initial begin
    logic [N-1:0]       pend, pw;
    logic [N-1:0][31:0] pa, pd;
    logic [31:0]        exp_data;
    int ptr, win, c, ack_dly, d, j, grants, exp_g;
    bit to, fire, done;

    // ---------------- reset state
    step(); step();
    chk("rst_ready", req_ready, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_data", resp_data, 0);
    chk("rst_resp_err", resp_err, 0);
    chk("rst_mem_cmd", mem_cmd, MEM_NONE);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    rst_n = 1'b1;

    // ---------------- single load from req0
    req_valid = 3'b001; req_write = '0; req_addr[0] = 32'h100;
    step();
    chk("ld_ready", req_ready, 3'b001);
    chk("ld_cmd", mem_cmd, MEM_LOAD);
    chk("ld_addr", mem_addr, 32'h100);
    req_valid = '0;
    step();
    chk("ld_ready_pulse", req_ready, 0);
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    chk("ld_cmd_none", mem_cmd, MEM_NONE);
    step(); step();
    chk("ld_no_early_resp", resp_valid, 0);
    mem_rvalid = 1'b1; mem_rdata = 32'hDEADBEEF;
    step();
    mem_rvalid = 1'b0;
    chk("ld_resp_valid", resp_valid, 3'b001);
    chk("ld_resp_data", resp_data, 32'hDEADBEEF);
    chk("ld_resp_err", resp_err, 0);
    step();
    chk("ld_resp_pulse", resp_valid, 0);

    // ---------------- store from req1
    req_valid = 3'b010; req_write = 3'b010; req_addr[1] = 32'h40; req_wdata[1] = 32'hCAFE;
    step();
    chk("st_ready", req_ready, 3'b010);
    chk("st_cmd", mem_cmd, MEM_STORE);
    chk("st_addr", mem_addr, 32'h40);
    chk("st_wdata", mem_wdata, 32'hCAFE);
    req_valid = '0; mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    chk("st_resp_valid", resp_valid, 3'b010);
    chk("st_cmd_none", mem_cmd, MEM_NONE);
    step();

    // ---------------- stall in ISSUE with stray rvalid
    req_valid = 3'b001; req_write = 3'b001; req_addr[0] = 32'h80; req_wdata[0] = 32'h1234;
    step();
    chk("stall_ready", req_ready, 3'b001);
    req_valid = '0;
    for (int k = 0; k < 10; k++) begin
      mem_rvalid = 1'b1;
      step();
      chk("stall_cmd", mem_cmd, MEM_STORE);
      chk("stall_addr", mem_addr, 32'h80);
      chk("stall_wdata", mem_wdata, 32'h1234);
      chk("stall_no_resp", resp_valid, 0);
    end
    mem_rvalid = 1'b0; mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    chk("stall_resp", resp_valid, 3'b001);
    step();

    // ---------------- watchdog timeout on a req1 load
    req_valid = 3'b010; req_write = '0; req_addr[1] = 32'h200;
    step();
    chk("to_ready", req_ready, 3'b010);
    req_valid = '0;
    step();
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    for (int k = 0; k < 7; k++) step();
    chk("to_not_yet", resp_valid, 0);
    step();
    chk("to_resp_valid", resp_valid, 3'b010);
    chk("to_resp_err", resp_err, 1);
    chk("to_resp_data", resp_data, 0);
    step();
    chk("to_err_pulse", resp_err, 0);

    // ---------------- rvalid on the expiry cycle is a success
    req_valid = 3'b001; req_write = '0; req_addr[0] = 32'h204;
    step();
    chk("edge_ready", req_ready, 3'b001);
    req_valid = '0;
    step();
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    for (int k = 0; k < 7; k++) step();
    mem_rvalid = 1'b1; mem_rdata = 32'h5A5A1234;
    step();
    mem_rvalid = 1'b0;
    chk("edge_resp_valid", resp_valid, 3'b001);
    chk("edge_resp_err", resp_err, 0);
    chk("edge_resp_data", resp_data, 32'h5A5A1234);
    step();

    // ---------------- reset in the middle of WAIT (pointer now at req1)
    req_valid = 3'b010; req_write = '0; req_addr[1] = 32'h300;
    step();
    req_valid = '0;
    step();
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    step();
    rst_n = 1'b0;
    #1;
    chk("mrst_addr", mem_addr, 0);
    chk("mrst_cmd", mem_cmd, MEM_NONE);
    chk("mrst_ready", req_ready, 0);
    mem_rvalid = 1'b1; mem_rdata = 32'h11111111;
    step(); step();
    chk("mrst_no_resp", resp_valid, 0);
    mem_rvalid = 1'b0;
    rst_n = 1'b1;

    // ---------------- fairness: req0 and req1 held, memory always acking
    req_valid = 3'b011; req_write = 3'b011;
    req_addr[0] = 32'hA0; req_addr[1] = 32'hA4;
    mem_ack = 1'b1;
    grants = 0; exp_g = 0;
    for (int k = 0; k < 30; k++) begin
      step();
      if (req_ready != '0) begin
        chk("fair_grant", req_ready, oh(exp_g));
        exp_g = 1 - exp_g;
        grants++;
      end
    end
    chk("fair_count", grants, 10);
    req_valid = '0; mem_ack = 1'b0;
    rst_n = 1'b0;
    step(); step();
    rst_n = 1'b1;

    // ---------------- randomized transactions vs transaction-level model
    ptr = 0; pend = '0; pw = '0; pa = '0; pd = '0;
    for (int t = 0; t < 40; t++) begin
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && ($urandom_range(0, 1) == 1)) begin
          pend[i] = 1'b1; pw[i] = 1'($urandom_range(0, 1));
          pa[i] = $urandom; pd[i] = $urandom;
        end
      end
      if (pend == '0) begin
        c = $urandom_range(0, N - 1);
        pend[c] = 1'b1; pw[c] = 1'($urandom_range(0, 1));
        pa[c] = $urandom; pd[c] = $urandom;
      end
      req_valid = pend; req_write = pw; req_addr = pa; req_wdata = pd;

      win = -1;
      for (int off = 0; off < N; off++) begin
        c = (ptr + off) % N;
        if (win < 0 && pend[c]) win = c;
      end

      step();
      chk("rnd_ready", req_ready, oh(win));
      chk("rnd_cmd", mem_cmd, pw[win] ? MEM_STORE : MEM_LOAD);
      chk("rnd_addr", mem_addr, pa[win]);
      chk("rnd_wdata", mem_wdata, pd[win]);
      pend[win] = 1'b0;
      req_valid = pend;

      ack_dly = $urandom_range(0, 3);
      for (int k = 0; k < ack_dly; k++) begin
        mem_rvalid = 1'($urandom_range(0, 1));
        step();
        chk("rnd_issue_hold", mem_cmd, pw[win] ? MEM_STORE : MEM_LOAD);
        chk("rnd_issue_ready", req_ready, 0);
        chk("rnd_issue_resp", resp_valid, 0);
      end
      mem_ack = 1'b1; mem_rvalid = 1'($urandom_range(0, 1));
      step();
      mem_ack = 1'b0; mem_rvalid = 1'b0;

      if (pw[win]) begin
        chk("rnd_st_resp", resp_valid, oh(win));
        chk("rnd_st_err", resp_err, 0);
        chk("rnd_st_cmd", mem_cmd, MEM_NONE);
      end else begin
        to = ($urandom_range(0, 4) == 0);
        d  = $urandom_range(0, TO - 1);
        j = 0; done = 0;
        while (!done) begin
          chk("rnd_wait_resp", resp_valid, 0);
          chk("rnd_wait_cmd", mem_cmd, MEM_NONE);
          chk("rnd_wait_ready", req_ready, 0);
          fire = !to && (j == d);
          exp_data = $urandom;
          mem_rvalid = fire; mem_rdata = exp_data;
          step();
          mem_rvalid = 1'b0;
          if (fire || j == TO - 1) begin
            chk("rnd_ld_resp", resp_valid, oh(win));
            chk("rnd_ld_err", resp_err, fire ? 1'b0 : 1'b1);
            chk("rnd_ld_data", resp_data, fire ? exp_data : 32'h0);
            done = 1;
          end
          j++;
        end
      end
      step();
      chk("rnd_idle_resp", resp_valid, 0);
      chk("rnd_idle_ready", req_ready, 0);
      ptr = (win + 1) % N;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
